pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. Detects load-use hazards between ID/EX and IF/ID, flushes on taken jumps resolved in EX, and holds the pipeline for multi-cycle memory accesses in MEM. Drives the write-enables and flushes of the PC, IF/ID, ID/EX and EX/MEM buffers. Drives the 16-bit data-memory request, including the two-half sequence for 32-bit PC stack push/pop.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/load_use_detect.sv | 22 ++
 rtl/pipeline_hazard_controller.sv | 198 +++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional performance counters are enabled with PIPE_PERF_CNT_EN.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_HI   = 2'd2
  } state_e;

  localparam int REG_ADDR_W   = 3;
  localparam int DEF_MAX_WAIT = 15;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in ID/EX whose destination is read by the instruction in IF/ID.
// Purely combinational, zero latency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] ifid_src1_i,
  input  logic [REG_ADDR_W-1:0] ifid_src2_i,
  input  logic                  ifid_use_src1_i,
  input  logic                  ifid_use_src2_i,
  input  logic                  idex_mr_i,
  input  logic                  idex_wb_i,
  input  logic [REG_ADDR_W-1:0] idex_wb_addr_i,
  output logic                  hazard_o
);

  logic hit1, hit2;

  assign hit1     = ifid_use_src1_i && (ifid_src1_i == idex_wb_addr_i);
  assign hit2     = ifid_use_src2_i && (ifid_src2_i == idex_wb_addr_i);
  assign hazard_o = idex_mr_i && idex_wb_i && (hit1 || hit2);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline and 16-bit data-memory handshake.
// Optional stall/flush performance counters are built only with PIPE_PERF_CNT_EN.
module pipeline_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ifid_src1,
  input  logic [REG_ADDR_W-1:0] ifid_src2,
  input  logic                  ifid_use_src1,
  input  logic                  ifid_use_src2,
  input  logic                  idex_mr,
  input  logic                  idex_wb,
  input  logic [REG_ADDR_W-1:0] idex_wb_addr,
  input  logic                  taken_jump,
  input  logic                  exmem_mr,
  input  logic                  exmem_mw,
  input  logic                  exmem_stack_pc,
  input  logic                  mem_ready,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  ifid_flush,
  output logic                  idex_we,
  output logic                  idex_flush,
  output logic                  exmem_we,
  output logic                  memwb_bubble,
  output logic                  mem_req,
  output logic                  mem_half,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                hi_q, hi_d;
  logic                mem_err_q, mem_err_d;
  logic                hazard, acc, freeze, timeout, mem_active, half;

  assign acc     = exmem_mr || exmem_mw;
  assign mem_err = mem_err_q;

  load_use_detect u_load_use_detect (
    .ifid_src1_i     (ifid_src1),
    .ifid_src2_i     (ifid_src2),
    .ifid_use_src1_i (ifid_use_src1),
    .ifid_use_src2_i (ifid_use_src2),
    .idex_mr_i       (idex_mr),
    .idex_wb_i       (idex_wb),
    .idex_wb_addr_i  (idex_wb_addr),
    .hazard_o        (hazard)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      hi_q       <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hi_q       <= hi_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    hi_d       = hi_q;
    mem_err_d  = mem_err_q;
    freeze     = 1'b0;
    timeout    = 1'b0;
    mem_active = 1'b0;
    half       = 1'b0;
    case (state_q)
      RUN: begin
        if (acc) begin
          mem_active = 1'b1;
          if (!mem_ready) begin
            freeze     = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
            hi_d       = 1'b0;
          end else if (exmem_stack_pc) begin
            freeze  = 1'b1;
            state_d = MEM_HI;
          end
        end
      end
      MEM_WAIT: begin
        mem_active = 1'b1;
        half       = hi_q;
        if (mem_ready) begin
          wait_cnt_d = '0;
          // A completed low half of a stack access still owes the high half.
          if (!hi_q && exmem_stack_pc) begin
            freeze  = 1'b1;
            state_d = MEM_HI;
          end else begin
            state_d = RUN;
          end
        end else if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
          timeout    = 1'b1;
          mem_err_d  = 1'b1;
          wait_cnt_d = '0;
          state_d    = RUN;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      MEM_HI: begin
        mem_active = 1'b1;
        half       = 1'b1;
        if (mem_ready) begin
          state_d = RUN;
        end else begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          hi_d       = 1'b1;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    ifid_flush   = 1'b0;
    idex_we      = 1'b0;
    idex_flush   = 1'b0;
    exmem_we     = 1'b0;
    memwb_bubble = 1'b0;
    mem_req      = 1'b0;
    mem_half     = 1'b0;
    if (reset) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      mem_req  = mem_active;
      mem_half = half;
      if (freeze) begin
        memwb_bubble = 1'b1;
      end else begin
        // A timed-out access still releases the pipeline, but MEM/WB gets a bubble.
        memwb_bubble = timeout;
        exmem_we     = 1'b1;
        idex_we      = 1'b1;
        if (taken_jump) begin
          pc_we      = 1'b1;
          ifid_we    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (hazard) begin
          idex_flush = 1'b1;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;

  assign stall_inc = freeze || (!taken_jump && hazard);
  assign flush_inc = !freeze && taken_jump;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized scoreboard bench for pipeline_hazard_controller against a behavioural model.
module tb_pipeline_hazard_controller;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 16;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic       reset;
    logic [2:0] src1, src2;
    logic       use1, use2, idex_mr, idex_wb;
    logic [2:0] wb_addr;
    logic       jump, mr, mw, stack, ready;
  } stim_t;

  typedef struct packed {
    logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble, mem_req, mem_half;
  } ctl_t;

  typedef struct {
    int         cyc;
    ctl_t       ctl;
    bit         chk_regs;
    logic       err;
    logic [CNT_W-1:0] stall, flush;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] ifid_src1, ifid_src2, idex_wb_addr;
  logic ifid_use_src1, ifid_use_src2, idex_mr, idex_wb, taken_jump;
  logic exmem_mr, exmem_mw, exmem_stack_pc, mem_ready;
  logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble;
  logic mem_req, mem_half, mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  pipeline_hazard_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ifid_src1(ifid_src1), .ifid_src2(ifid_src2),
    .ifid_use_src1(ifid_use_src1), .ifid_use_src2(ifid_use_src2),
    .idex_mr(idex_mr), .idex_wb(idex_wb), .idex_wb_addr(idex_wb_addr),
    .taken_jump(taken_jump),
    .exmem_mr(exmem_mr), .exmem_mw(exmem_mw), .exmem_stack_pc(exmem_stack_pc),
    .mem_ready(mem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_we(idex_we), .idex_flush(idex_flush), .exmem_we(exmem_we),
    .memwb_bubble(memwb_bubble), .mem_req(mem_req), .mem_half(mem_half),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: an access is "busy" until both needed halves complete or it times out.
  bit               m_known = 0;
  bit               m_busy  = 0;
  bit               m_half  = 0;
  int               m_waits = 0;
  bit               m_err   = 0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  task automatic step(input stim_t s);
    exp_t e;
    bit acc, haz, frz, tmo;
    @(posedge clk);
    #1;
    reset = s.reset; ifid_src1 = s.src1; ifid_src2 = s.src2;
    ifid_use_src1 = s.use1; ifid_use_src2 = s.use2;
    idex_mr = s.idex_mr; idex_wb = s.idex_wb; idex_wb_addr = s.wb_addr;
    taken_jump = s.jump; exmem_mr = s.mr; exmem_mw = s.mw;
    exmem_stack_pc = s.stack; mem_ready = s.ready;
    e.cyc = cyc; cyc++;
    e.ctl = '0;
    e.chk_regs = 1'b0; e.err = 1'b0; e.stall = '0; e.flush = '0;
    if (s.reset) begin
      e.ctl.ifid_flush = 1'b1; e.ctl.idex_flush = 1'b1; e.ctl.memwb_bubble = 1'b1;
      m_known = 1; m_busy = 0; m_half = 0; m_waits = 0; m_err = 0;
      m_stall = '0; m_flush = '0;
    end else begin
      e.chk_regs = m_known;
      e.err   = m_err;
      e.stall = PERF ? m_stall : '0;
      e.flush = PERF ? m_flush : '0;
      acc = s.mr || s.mw;
      frz = 0; tmo = 0;
      e.ctl.mem_req  = m_busy || acc;
      e.ctl.mem_half = m_busy && m_half;
      if (m_busy || acc) begin
        if (!s.ready) begin
          if (m_waits == MAX_WAIT) begin
            tmo = 1; m_err = 1; m_busy = 0; m_half = 0; m_waits = 0;
          end else begin
            frz = 1; m_busy = 1; m_waits++;
          end
        end else begin
          m_waits = 0;
          if (!m_half && s.stack) begin
            frz = 1; m_busy = 1; m_half = 1;
          end else begin
            m_busy = 0; m_half = 0;
          end
        end
      end
      haz = s.idex_mr && s.idex_wb &&
            ((s.use1 && s.src1 == s.wb_addr) || (s.use2 && s.src2 == s.wb_addr));
      if (frz) begin
        e.ctl.memwb_bubble = 1'b1;
        if (m_stall != '1) m_stall++;
      end else begin
        e.ctl.memwb_bubble = tmo;
        e.ctl.exmem_we = 1'b1;
        e.ctl.idex_we  = 1'b1;
        if (s.jump) begin
          e.ctl.pc_we = 1'b1; e.ctl.ifid_we = 1'b1;
          e.ctl.ifid_flush = 1'b1; e.ctl.idex_flush = 1'b1;
          if (m_flush != '1) m_flush++;
        end else if (haz) begin
          e.ctl.idex_flush = 1'b1;
          if (m_stall != '1) m_stall++;
        end else begin
          e.ctl.pc_we = 1'b1; e.ctl.ifid_we = 1'b1;
        end
      end
    end
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    ctl_t got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        got = '{pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
                memwb_bubble, mem_req, mem_half};
        checks++;
        if (got !== e.ctl) begin
          errors++;
          $display("FAIL ctl cycle %0d: got %b expected %b", e.cyc, got, e.ctl);
        end
        if (e.chk_regs) begin
          checks++;
          if (mem_err !== e.err) begin
            errors++;
            $display("FAIL mem_err cycle %0d: got %b expected %b", e.cyc, mem_err, e.err);
          end
          checks++;
          if (stall_cycles !== e.stall) begin
            errors++;
            $display("FAIL stall_cycles cycle %0d: got %0d expected %0d", e.cyc, stall_cycles, e.stall);
          end
          checks++;
          if (flush_events !== e.flush) begin
            errors++;
            $display("FAIL flush_events cycle %0d: got %0d expected %0d", e.cyc, flush_events, e.flush);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, queue depth %0d", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    stim_t s;
    int    ready_pct;
    s = '0; s.reset = 1'b1; s.mr = 1'b1;
    step(s); step(s);
    s = '0; step(s);
    // load-use on src2, then the bubble clears it
    s = '0; s.idex_mr = 1; s.idex_wb = 1; s.wb_addr = 3'd3; s.src2 = 3'd3; s.use2 = 1;
    step(s);
    s.idex_mr = 0; step(s);
    // jump beats load-use
    s = '0; s.idex_mr = 1; s.idex_wb = 1; s.wb_addr = 3'd5; s.src1 = 3'd5; s.use1 = 1; s.jump = 1;
    step(s);
    // three not-ready cycles then completion
    s = '0; s.mr = 1;
    repeat (3) step(s);
    s.ready = 1; step(s);
    s = '0; step(s);
    // stack push, both halves ready immediately
    s = '0; s.mw = 1; s.stack = 1; s.ready = 1;
    step(s); step(s);
    s = '0; step(s);
    // stack access with a stalled high half
    s = '0; s.mr = 1; s.stack = 1; s.ready = 1; step(s);
    s.ready = 0; step(s); step(s);
    s.ready = 1; step(s);
    s = '0; step(s);
    // timeout: ready never comes
    s = '0; s.mr = 1;
    repeat (MAX_WAIT + 1) step(s);
    s = '0; repeat (3) step(s);
    // randomized traffic
    ready_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        case ($urandom_range(0, 3))
          0: ready_pct = 0;
          1: ready_pct = 30;
          2: ready_pct = 70;
          default: ready_pct = 100;
        endcase
      end
      s.reset   = ($urandom_range(0, 499) == 0);
      s.src1    = 3'($urandom_range(0, 3));
      s.src2    = 3'($urandom_range(0, 3));
      s.wb_addr = 3'($urandom_range(0, 3));
      s.use1    = 1'($urandom);
      s.use2    = 1'($urandom);
      s.idex_mr = 1'($urandom);
      s.idex_wb = 1'($urandom);
      s.jump    = ($urandom_range(0, 5) == 0);
      s.mr      = ($urandom_range(0, 3) == 0);
      s.mw      = ($urandom_range(0, 5) == 0);
      s.stack   = 1'($urandom);
      s.ready   = ($urandom_range(0, 99) < ready_pct);
      step(s);
    end
    s = '0; step(s);
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
